mjr_regfile_scrub: RTL and testbench
====================================

Name: mjr_regfile_scrub

Overview:
- Triple-modular-redundant (TMR) register file: DEPTH words of WIDTH bits, each word stored as three independent replicas and read through a bitwise 2-of-3 majority voter.
- Generalises the single TMR register to an addressable array with a registered read port and error classification.
- Adds a background scrubber FSM that walks the array and rewrites corrupted words with the voted value.
- Sits between the hash pipeline stages and their coefficient/state storage.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 16, number of words (>=2); address width AW = $clog2(DEPTH).
- CNT_W, 16, width of the saturating corrected-error counter.

Ports:
- clk  in  1  clock.
- rstN  in  1  reset, synchronous, active-low.
- we  in  1  write enable; writes wdata_1/2/3 to replicas 1/2/3 at waddr.
- waddr  in  AW  write address.
- wdata_1, wdata_2, wdata_3  in  WIDTH  per-channel write data.
- re  in  1  read request.
- raddr  in  AW  read address.
- rdata  out  WIDTH  voted read data.
- rvalid  out  1  read data valid.
- rerr_corr  out  1  read word had exactly one disagreeing replica (corrected).
- rerr_multi  out  1  two or more replicas disagree with the voted word.
- scrub_en  in  1  enables background scrubbing.
- scrub_busy  out  1  scrubber not in SC_IDLE.
- scrub_wrap  out  1  one-cycle pulse when the scrub pointer wraps DEPTH-1 -> 0.
- fix_cnt  out  CNT_W  number of words repaired by the scrubber (saturating).

Behaviour:
- Reset (rstN=0 at posedge clk): all replicas = 0; rdata = 0; rvalid = 0; rerr_corr = 0; rerr_multi = 0; scrub pointer = 0; FSM = SC_IDLE; fix_cnt = 0; scrub_wrap = 0. Reset mid-scrub aborts immediately; no write-back occurs.
- Write: when we=1, all three replicas at waddr update at the next edge. Per-channel data is stored unvoted.
- Read: re=1 samples raddr. On the next cycle rvalid=1 and rdata = vote(r1, r2, r3) of the array contents before any same-edge write (read-before-write). When re=0, rvalid=0 and rdata holds its previous value.
- Error classification: per replica, chan_err_i = (ri != voted).
  - rerr_corr = exactly one chan_err set.
  - rerr_multi = two or more set.
  - Both flags are registered with rdata and are 0 when rvalid=0.
- Scrubber FSM:
  - SC_IDLE -> SC_CHECK when scrub_en=1.
  - SC_CHECK: vote replicas at ptr via the internal voter port.
    - Any chan_err -> SC_FIX.
    - Otherwise advance ptr; stay in SC_CHECK if scrub_en=1, else go to SC_IDLE.
  - SC_FIX: write the voted value (latched in SC_CHECK) into all three replicas at ptr, fix_cnt += 1 (saturates at all-ones), advance ptr. Next state is SC_CHECK if scrub_en=1, else SC_IDLE.
  - Deasserting scrub_en never aborts an in-progress SC_FIX.
- Pointer: wraps DEPTH-1 -> 0 (non-power-of-two DEPTH supported). scrub_wrap is registered and pulses on the cycle following the wrap.
- Collisions:
  - User write wins over scrub. If we=1 and waddr==ptr during SC_FIX, the scrub write-back is dropped, fix_cnt is not incremented, and ptr still advances.
  - If a user write hits ptr during SC_CHECK, the latched vote is discarded and the state returns to SC_CHECK at the same ptr.
  - Scrub activity never stalls or alters the user read port.
- Multi-error words (rerr_multi class) found by the scrubber are still rewritten with the bitwise vote.

Optional Feature:
- Macro: MJR_REGFILE_CHAN_CNT_EN.
- Defined:
  - Adds output chan_err_cnt [3][CNT_W], one saturating counter per replica channel.
  - A counter increments by 1 each time the scrubber finds its replica disagreeing in SC_CHECK.
  - All counters reset to 0.
- Undefined: the port and counters are absent; all other behaviour is identical.

Decomposition:
- Package mjr_pkg holds:
  - typedef enum logic [1:0] {SC_IDLE, SC_CHECK, SC_FIX} scrub_state_t;
  - a vote3 function for bitwise majority;
  - constant N_CHAN = 3.
- Sub-module mjr_vote3 (parameter WIDTH):
  - combinational voter returning the voted word, chan_err[2:0], err_corr and err_multi;
  - instantiated twice, for the read port and the scrub port.

Test Plan:
- Reset then read all addresses -> rdata=0, rvalid=1 one cycle after each re, rerr_corr=0, rerr_multi=0, fix_cnt=0.
- Write addr 3 with wdata_1=0xA5A5A5A5, wdata_2=0xA5A5A5A5, wdata_3=0x00000000; read 3 -> rdata=0xA5A5A5A5, rerr_corr=1, rerr_multi=0.
- Write addr 5 with 0x0F, 0xF0, 0xFF (WIDTH=8 build) -> rdata=0xFF, rerr_multi=1.
- From the addr-3 fault state, set scrub_en=1 for one full pass:
  - fix_cnt=1 and scrub_wrap pulses once;
  - a subsequent read of addr 3 gives rerr_corr=0;
  - with MJR_REGFILE_CHAN_CNT_EN defined, chan_err_cnt[2]=1.
- Force we=1, waddr==ptr during SC_FIX with clean data -> written data survives, fix_cnt unchanged, ptr advances.
- Assert rstN=0 mid-pass in SC_FIX -> next cycle FSM=SC_IDLE, ptr=0, fix_cnt=0, all words read 0.

Source files
------------

// File: rtl/mjr_pkg.sv
// Shared types and helpers for the TMR register file: scrubber states,
// replica count and the single-bit majority function used by the voters.
package mjr_pkg;

  localparam int N_CHAN = 3;

  typedef enum logic [1:0] {SC_IDLE, SC_CHECK, SC_FIX} scrub_state_t;

  function automatic logic vote3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/mjr_vote3.sv
// Combinational 2-of-3 bitwise voter with per-replica disagreement flags
// and single/multi error classification.
module mjr_vote3
  import mjr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]  r1,
  input  logic [WIDTH-1:0]  r2,
  input  logic [WIDTH-1:0]  r3,
  output logic [WIDTH-1:0]  voted,
  output logic [N_CHAN-1:0] chan_err,
  output logic              err_corr,
  output logic              err_multi
);

  always_comb begin
    voted = '0;
    for (int b = 0; b < WIDTH; b++) begin
      voted[b] = vote3(r1[b], r2[b], r3[b]);
    end
  end

  assign chan_err[0] = (r1 != voted);
  assign chan_err[1] = (r2 != voted);
  assign chan_err[2] = (r3 != voted);

  // Odd parity without all three set means exactly one replica is off.
  assign err_corr  = (^chan_err) & ~(&chan_err);
  assign err_multi = (chan_err[0] & chan_err[1]) | (chan_err[0] & chan_err[2]) |
                     (chan_err[1] & chan_err[2]);

endmodule

// File: rtl/mjr_regfile_scrub.sv
// TMR register file with a voted registered read port and a background scrubber.
// Define MJR_REGFILE_CHAN_CNT_EN to add per-replica disagreement counters.
module mjr_regfile_scrub
  import mjr_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata_1,
  input  logic [WIDTH-1:0]         wdata_2,
  input  logic [WIDTH-1:0]         wdata_3,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata,
  output logic                     rvalid,
  output logic                     rerr_corr,
  output logic                     rerr_multi,
  input  logic                     scrub_en,
  output logic                     scrub_busy,
  output logic                     scrub_wrap,
  output logic [CNT_W-1:0]         fix_cnt,
`ifdef MJR_REGFILE_CHAN_CNT_EN
  output logic [CNT_W-1:0]         chan_err_cnt [N_CHAN],
`endif
  output logic [1:0]               dbgState,
  output logic [$clog2(DEPTH)-1:0] dbgPtr
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [WIDTH-1:0] mem2 [DEPTH];
  logic [WIDTH-1:0] mem3 [DEPTH];

  scrub_state_t     state, stateNext;
  logic [AW-1:0]    ptr, ptrNext;
  logic [WIDTH-1:0] fixData;
  logic             ptrAdv, doFix, latchVote, userHit, ptrLast;

  logic [WIDTH-1:0]  rVoted, sVoted;
  logic [N_CHAN-1:0] rErr, sErr;
  logic              rCorr, rMulti, sCorr, sMulti;

  mjr_vote3 #(.WIDTH(WIDTH)) uReadVote (
    .r1(mem1[raddr]), .r2(mem2[raddr]), .r3(mem3[raddr]),
    .voted(rVoted), .chan_err(rErr), .err_corr(rCorr), .err_multi(rMulti)
  );

  mjr_vote3 #(.WIDTH(WIDTH)) uScrubVote (
    .r1(mem1[ptr]), .r2(mem2[ptr]), .r3(mem3[ptr]),
    .voted(sVoted), .chan_err(sErr), .err_corr(sCorr), .err_multi(sMulti)
  );

  assign userHit    = we && (waddr == ptr);
  assign ptrLast    = (ptr == AW'(DEPTH - 1));
  assign ptrNext    = ptrLast ? '0 : ptr + 1'b1;
  assign scrub_busy = (state != SC_IDLE);
  assign dbgState   = state;
  assign dbgPtr     = ptr;

  // A user write to the word under inspection invalidates the vote, so the
  // check is simply repeated; a colliding fix is dropped but still moves on.
  always_comb begin
    stateNext = state;
    ptrAdv    = 1'b0;
    doFix     = 1'b0;
    latchVote = 1'b0;
    case (state)
      SC_IDLE: if (scrub_en) stateNext = SC_CHECK;
      SC_CHECK: begin
        if (userHit) begin
          stateNext = SC_CHECK;
        end else if (|sErr) begin
          stateNext = SC_FIX;
          latchVote = 1'b1;
        end else begin
          ptrAdv    = 1'b1;
          stateNext = scrub_en ? SC_CHECK : SC_IDLE;
        end
      end
      SC_FIX: begin
        ptrAdv    = 1'b1;
        doFix     = !userHit;
        stateNext = scrub_en ? SC_CHECK : SC_IDLE;
      end
      default: stateNext = SC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem1[i] <= '0;
        mem2[i] <= '0;
        mem3[i] <= '0;
      end
      state      <= SC_IDLE;
      ptr        <= '0;
      fixData    <= '0;
      fix_cnt    <= '0;
      scrub_wrap <= 1'b0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      rerr_corr  <= 1'b0;
      rerr_multi <= 1'b0;
    end else begin
      state      <= stateNext;
      scrub_wrap <= ptrAdv && ptrLast;
      if (ptrAdv) ptr <= ptrNext;
      if (latchVote) fixData <= sVoted;
      if (doFix) begin
        mem1[ptr] <= fixData;
        mem2[ptr] <= fixData;
        mem3[ptr] <= fixData;
        if (fix_cnt != '1) fix_cnt <= fix_cnt + 1'b1;
      end
      if (we) begin
        mem1[waddr] <= wdata_1;
        mem2[waddr] <= wdata_2;
        mem3[waddr] <= wdata_3;
      end
      rvalid <= re;
      if (re) begin
        rdata      <= rVoted;
        rerr_corr  <= rCorr;
        rerr_multi <= rMulti;
      end else begin
        rerr_corr  <= 1'b0;
        rerr_multi <= 1'b0;
      end
    end
  end

`ifdef MJR_REGFILE_CHAN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rstN) begin
      for (int c = 0; c < N_CHAN; c++) chan_err_cnt[c] <= '0;
    end else if (latchVote) begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (sErr[c] && chan_err_cnt[c] != '1) chan_err_cnt[c] <= chan_err_cnt[c] + 1'b1;
      end
    end
  end
`endif

  logic unusedVote;
  assign unusedVote = sCorr ^ sMulti;

endmodule

// File: tb/tb_mjr_regfile_scrub.sv
// Directed bench for mjr_regfile_scrub: vector table for write/vote/classify,
// plus hand sequences for scrubbing, fix collisions and reset mid-fix.
module tb_mjr_regfile_scrub;
  import mjr_pkg::*;

  logic        clk = 1'b0;
  logic        rstN, we, re, scrub_en;
  logic [3:0]  waddr, raddr;
  logic [31:0] wdata_1, wdata_2, wdata_3, rdata;
  logic        rvalid, rerr_corr, rerr_multi, scrub_busy, scrub_wrap;
  logic [15:0] fix_cnt;
  logic [1:0]  dbgState;
  logic [3:0]  dbgPtr;
`ifdef MJR_REGFILE_CHAN_CNT_EN
  logic [15:0] chan_err_cnt [3];
`endif

  int checks = 0;
  int errors = 0;

  mjr_regfile_scrub #(.WIDTH(32), .DEPTH(16), .CNT_W(16)) dut (
    .clk(clk), .rstN(rstN), .we(we), .waddr(waddr),
    .wdata_1(wdata_1), .wdata_2(wdata_2), .wdata_3(wdata_3),
    .re(re), .raddr(raddr), .rdata(rdata), .rvalid(rvalid),
    .rerr_corr(rerr_corr), .rerr_multi(rerr_multi),
    .scrub_en(scrub_en), .scrub_busy(scrub_busy), .scrub_wrap(scrub_wrap),
    .fix_cnt(fix_cnt),
`ifdef MJR_REGFILE_CHAN_CNT_EN
    .chan_err_cnt(chan_err_cnt),
`endif
    .dbgState(dbgState), .dbgPtr(dbgPtr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] w1, w2, w3;
    logic [31:0] expData;
    logic        expCorr, expMulti;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic write_word(input logic [3:0] a, input logic [31:0] d1, d2, d3);
    we = 1'b1; waddr = a; wdata_1 = d1; wdata_2 = d2; wdata_3 = d3;
    tick();
    we = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [3:0] a, input logic [31:0] expData,
                            input logic expCorr, input logic expMulti);
    re = 1'b1; raddr = a;
    tick();
    re = 1'b0;
    check({name, "_rvalid"}, 32'(rvalid), 32'd1);
    check({name, "_rdata"}, rdata, expData);
    check({name, "_corr"}, 32'(rerr_corr), 32'(expCorr));
    check({name, "_multi"}, 32'(rerr_multi), 32'(expMulti));
  endtask

  task automatic wait_fix(input string name);
    for (int i = 0; i < 40; i++) begin
      if (dbgState == 2'(SC_FIX)) break;
      tick();
    end
    check(name, 32'(dbgState), 32'(SC_FIX));
  endtask

  initial begin
    int wraps;
    rstN = 1'b0; we = 1'b0; re = 1'b0; scrub_en = 1'b0;
    waddr = '0; raddr = '0; wdata_1 = '0; wdata_2 = '0; wdata_3 = '0;

    vecs[0] = '{4'd3,  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h00000000, 32'hA5A5A5A5, 1'b1, 1'b0};
    vecs[1] = '{4'd5,  32'h0000000F, 32'h000000F0, 32'h000000FF, 32'h000000FF, 1'b0, 1'b1};
    vecs[2] = '{4'd7,  32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b0, 1'b0};
    vecs[3] = '{4'd9,  32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b0};
    vecs[4] = '{4'd12, 32'h00000001, 32'h00000002, 32'h00000004, 32'h00000000, 1'b0, 1'b1};
    vecs[5] = '{4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFF0000, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[6] = '{4'd0,  32'hF0F0F0F0, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'hF0F0F0F0, 1'b1, 1'b0};

    tick(); tick();
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_fix_cnt", 32'(fix_cnt), 32'd0);
    check("rst_state", 32'(dbgState), 32'(SC_IDLE));
    check("rst_ptr", 32'(dbgPtr), 32'd0);
    rstN = 1'b1;
    for (int a = 0; a < 16; a++) read_check("rst_read", 4'(a), 32'd0, 1'b0, 1'b0);

    for (int v = 0; v < 7; v++) begin
      write_word(vecs[v].addr, vecs[v].w1, vecs[v].w2, vecs[v].w3);
      read_check($sformatf("vec%0d", v), vecs[v].addr, vecs[v].expData, vecs[v].expCorr, vecs[v].expMulti);
    end

    // rdata holds and flags clear while no read is requested
    tick();
    check("idle_rvalid", 32'(rvalid), 32'd0);
    check("idle_hold", rdata, 32'hF0F0F0F0);
    check("idle_corr", 32'(rerr_corr), 32'd0);

    // read-before-write on the same edge
    re = 1'b1; raddr = 4'd7;
    write_word(4'd7, 32'h9, 32'h9, 32'h9);
    re = 1'b0;
    check("rbw_old", rdata, 32'h12345678);
    read_check("rbw_new", 4'd7, 32'h9, 1'b0, 1'b0);

    // leave only addr 3 faulty, then one full scrub pass
    write_word(4'd5, 32'h5, 32'h5, 32'h5);
    write_word(4'd9, 32'h9, 32'h9, 32'h9);
    write_word(4'd12, 32'hC, 32'hC, 32'hC);
    write_word(4'd15, 32'hF, 32'hF, 32'hF);
    write_word(4'd0, 32'h0, 32'h0, 32'h0);
    wraps = 0;
    scrub_en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (scrub_wrap) begin
        wraps++;
        break;
      end
    end
    scrub_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (scrub_wrap) wraps++;
    end
    check("pass_wraps", 32'(wraps), 32'd1);
    check("pass_fix_cnt", 32'(fix_cnt), 32'd1);
    check("pass_busy", 32'(scrub_busy), 32'd0);
    check("pass_ptr", 32'(dbgPtr), 32'd1);
    read_check("pass_addr3", 4'd3, 32'hA5A5A5A5, 1'b0, 1'b0);
`ifdef MJR_REGFILE_CHAN_CNT_EN
    check("chan_cnt2", 32'(chan_err_cnt[2]), 32'd1);
    check("chan_cnt0", 32'(chan_err_cnt[0]), 32'd0);
`endif

    // user write collides with the scrub write-back
    write_word(4'd6, 32'h11, 32'h22, 32'h11);
    scrub_en = 1'b1;
    wait_fix("coll_reach_fix");
    check("coll_ptr_at_fix", 32'(dbgPtr), 32'd6);
    scrub_en = 1'b0;
    write_word(4'd6, 32'h77, 32'h77, 32'h77);
    check("coll_fix_cnt", 32'(fix_cnt), 32'd1);
    check("coll_ptr_adv", 32'(dbgPtr), 32'd7);
    check("coll_state", 32'(dbgState), 32'(SC_IDLE));
    read_check("coll_data", 4'd6, 32'h77, 1'b0, 1'b0);

    // reset while a fix is pending
    write_word(4'd10, 32'h3, 32'h3, 32'h8);
    scrub_en = 1'b1;
    wait_fix("rst_reach_fix");
    rstN = 1'b0;
    tick();
    scrub_en = 1'b0;
    check("rstfix_state", 32'(dbgState), 32'(SC_IDLE));
    check("rstfix_ptr", 32'(dbgPtr), 32'd0);
    check("rstfix_fix_cnt", 32'(fix_cnt), 32'd0);
    check("rstfix_wrap", 32'(scrub_wrap), 32'd0);
    rstN = 1'b1;
    for (int a = 0; a < 16; a++) read_check("rstfix_read", 4'(a), 32'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
